priority_decoder: RTL
=====================

# priority_decoder

Registered 3-to-8 decoder that converts an encoded index and valid flag back into a one-hot vector, held for a programmable number of cycles per code. It takes the `xin`/`v` pair produced by the 8-to-3 priority encoder and drives one-hot select lines to downstream request/enable logic. A one-entry pending buffer and a ready signal let the upstream stream codes back-to-back without loss.

## Interface
- `PULSE_LEN`, default 4: cycles each accepted code is driven on `d`. Legal range is 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `xin`  in  3  encoded index, 0..7. Ignored when `v`=0, and may be X in that case.
- `v`  in  1  `xin` valid; a code is accepted on a rising edge where `v`=1 and `in_ready`=1.
- `in_ready`  out  1  block can accept a code this cycle; equals `!pend_valid`.
- `d`  out  8  one-hot decoded vector, `1 << code_q`, while driving; 8'h00 otherwise.
- `d_valid`  out  1  high while `d` carries a code.
- `busy`  out  1  high when state is DRIVE or the pending buffer is full.

## Operation
- State machine with two states: IDLE and DRIVE.
- Registers:
  - `code_q[2:0]`
  - `cnt[3:0]`
  - `pend_code[2:0]`
  - `pend_valid`
- Accept is defined as `v && in_ready` at a rising edge.
- IDLE:
  - On accept: `code_q <= xin`, `cnt <= PULSE_LEN-1`, go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE, with `cnt != 0`:
  - `cnt` decrements by 1.
  - On accept: `pend_code <= xin`, `pend_valid <= 1`.
- DRIVE, with `cnt == 0` (last drive cycle), priority order:
  1. If `pend_valid`: `code_q <= pend_code`, `pend_valid <= 0`, `cnt <= PULSE_LEN-1`, stay in DRIVE.
  2. Else on accept: `code_q <= xin` directly, `cnt <= PULSE_LEN-1`, stay in DRIVE.
  3. Else go to IDLE.
- `d` and `d_valid` are registered outputs:
  - In DRIVE: `d = 8'b1 << code_q`, `d_valid = 1`.
  - In IDLE: `d = 8'h00`, `d_valid = 0`.
- Exactly one bit of `d` is set whenever `d_valid` is 1. `d` is never non-zero while `d_valid` is 0.
- When the pending buffer is full, `in_ready` is 0. A code held on `xin`/`v` is not accepted and the upstream must hold it.
- `v`=1 with `xin` containing X/Z is illegal upstream. No behaviour is required for it and the bench does not check it.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - `d` = 8'h00, `d_valid` = 0, `busy` = 0, `in_ready` = 1.
  - state = IDLE, `cnt` = 0, `code_q` = 0, `pend_valid` = 0.
- Reset takes effect immediately, including in the middle of a drive. Any pending code is discarded.
- Latency: a code accepted at edge N appears on `d` after edge N and holds for exactly `PULSE_LEN` cycles (edges N+1..N+PULSE_LEN bound the window).
- Back-to-back codes run with zero idle cycles between them. Sustained throughput is one code per `PULSE_LEN` cycles.
- `PULSE_LEN`=1:
  - The pending buffer is never used.
  - `in_ready` stays 1.
  - One code is accepted and driven per cycle.
- Simultaneous events:
  - Last drive cycle with `pend_valid`=1: the pending code is promoted. `in_ready` is 0, so no new accept occurs that cycle.
  - Last drive cycle with the pending buffer empty and `v`=1: `xin` loads straight into `code_q`. It is not routed through the pending buffer.
- `in_ready` is combinational only from `pend_valid`. It has no path from `v` or `xin`.

## Test plan
- Reset, then `PULSE_LEN`=4, `xin`=3'b101, `v`=1 for 1 cycle -> `d`=8'b0010_0000 with `d_valid`=1 for exactly 4 cycles, then `d`=8'h00, `d_valid`=0, `busy`=0.
- Codes 3, then 6 accepted while driving 3 -> `d`=8'h08 for 4 cycles immediately followed by `d`=8'h40 for 4 cycles, with no gap; `in_ready`=0 from acceptance of 6 until 6 is promoted.
- Three codes 0, 1, 7 presented with `v` held high -> 0 accepted, 1 pended, `in_ready`=0 stalls 7 until 1 is promoted; output sequence is 8'h01, 8'h02, 8'h80, each for 4 cycles, with no codes lost or duplicated.
- `v`=0 with `xin`=3'bxxx for 10 cycles from IDLE -> `d`=8'h00, `d_valid`=0, `in_ready`=1 throughout.
- Assert `rst_n`=0 asynchronously at cycle 2 of driving code 4 while a code is pending -> `d`=8'h00, `d_valid`=0, `in_ready`=1 immediately; after release, no stale code appears.
- `PULSE_LEN`=1, stream 0..7 with `v`=1 every cycle -> `d` walks 8'h01..8'h80, one per cycle, one cycle after each accept; `in_ready` stays 1.

Source files
------------

// File: rtl/priority_decoder_if.sv
// priority_decoder_if: encoded-code input stream and one-hot output bundle of the decoder
interface priority_decoder_if;
    logic [2:0] xin;
    logic       v;
    logic       in_ready;
    logic [7:0] d;
    logic       d_valid;
    logic       busy;
    modport master (output xin, v, input in_ready, d, d_valid, busy);
    modport slave (input xin, v, output in_ready, d, d_valid, busy);
endinterface

// File: rtl/priority_decoder.sv
// priority_decoder: registered 3-to-8 decoder holding each code for PULSE_LEN cycles with a one-entry pending buffer
module priority_decoder #(
    parameter int PULSE_LEN = 4
) (
    input logic clk,
    input logic rst_n,
    priority_decoder_if.slave bus
);
    typedef enum logic {IDLE, DRIVE} state_t;
    localparam logic [3:0] LAST = 4'(PULSE_LEN - 1);
    state_t state, state_nx;
    logic [2:0] code_q, code_nx, pend_code, pend_code_nx;
    logic [3:0] cnt, cnt_nx;
    logic pend_valid, pend_valid_nx, accept;
    assign accept = bus.v && !pend_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            code_q <= '0;
            cnt <= '0;
            pend_code <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_nx;
            code_q <= code_nx;
            cnt <= cnt_nx;
            pend_code <= pend_code_nx;
            pend_valid <= pend_valid_nx;
        end
    end
    always_comb begin
        state_nx = state;
        code_nx = code_q;
        cnt_nx = cnt;
        pend_code_nx = pend_code;
        pend_valid_nx = pend_valid;
        if (state == IDLE) begin
            if (accept) begin
                code_nx = bus.xin;
                cnt_nx = LAST;
                state_nx = DRIVE;
            end
        end else if (cnt != 4'd0) begin
            cnt_nx = cnt - 4'd1;
            if (accept) begin
                pend_code_nx = bus.xin;
                pend_valid_nx = 1'b1;
            end
        end else if (pend_valid) begin
            code_nx = pend_code;
            pend_valid_nx = 1'b0;
            cnt_nx = LAST;
        end else if (accept) begin
            // empty buffer on the last cycle: load straight into the drive register
            code_nx = bus.xin;
            cnt_nx = LAST;
        end else begin
            state_nx = IDLE;
        end
    end
    assign bus.in_ready = !pend_valid;
    assign bus.d = (state == DRIVE) ? 8'b1 << code_q : 8'h00;
    assign bus.d_valid = state == DRIVE;
    assign bus.busy = state == DRIVE || pend_valid;
endmodule
